// File: rtl/timer_pkg.sv
// Shared definitions for the timer register interface: register map, field
// positions, reset values and the bus protocol state encoding.
package timer_pkg;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TIER = 8'h03;
  localparam logic [7:0] ADDR_MAX  = ADDR_TIER;

  localparam int TCR_LOAD    = 7;
  localparam int TCR_UP_DOWN = 5;
  localparam int TCR_ENABLE  = 4;
  localparam int TCR_CKS_LSB = 0;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  localparam int TIER_OVF_IE = 0;
  localparam int TIER_UDF_IE = 1;

  localparam logic [7:0] TDR_RST  = 8'h00;
  localparam logic [7:0] TCR_RST  = 8'h00;
  localparam logic [7:0] TIER_RST = 8'h00;

  // Storage masks: LOAD is a strobe and never held, unlisted bits read 0.
  localparam logic [7:0] TCR_STORE_MASK  = 8'h33;
  localparam logic [7:0] TIER_STORE_MASK = 8'h03;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  function automatic logic addr_valid(input logic [7:0] addr);
    return addr <= ADDR_MAX;
  endfunction

endpackage

// File: rtl/timer_apb_if.sv
// APB slave protocol tracker: turns the psel/penable handshake into
// single-cycle write, read and address-error strobes for the register file.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   APB_IDLE   | no transfer in progress
//   APB_SETUP  | setup phase seen, waiting for penable
//   APB_ACCESS | transfer completes this cycle, pready high
module timer_apb_if
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  output logic       pready,
  output logic       wr_en,
  output logic       rd_en,
  output logic       addr_err
);

  apb_state_e state_q, state_d;
  logic       live;

  always_comb begin
    state_d = state_q;
    case (state_q)
      APB_IDLE: begin
        if (psel && !penable) state_d = APB_SETUP;
      end
      APB_SETUP: begin
        if (!psel)         state_d = APB_IDLE;
        else if (penable)  state_d = APB_ACCESS;
      end
      APB_ACCESS: begin
        if (psel && !penable) state_d = APB_SETUP;
        else                  state_d = APB_IDLE;
      end
      default: state_d = APB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= APB_IDLE;
    else     state_q <= state_d;
  end

  assign pready   = (state_q == APB_ACCESS);
  assign live     = pready && psel && penable;
  assign addr_err = live && !addr_valid(paddr);
  assign wr_en    = live && addr_valid(paddr) && pwrite;
  assign rd_en    = live && addr_valid(paddr) && !pwrite;

endmodule

// File: rtl/timer_reg_if.sv
// Timer configuration registers behind an APB slave port: reload value,
// control, live status with write-1-to-clear strobes, and interrupt enables.
module timer_reg_if
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [7:0] start_counter,
  output logic       up_down,
  output logic       load,
  output logic       enable,
  output logic       clr_overflow,
  output logic       clr_underflow,
  input  logic       overflow,
  input  logic       underflow,
  output logic [1:0] cks,
  output logic       irq
);

  logic       wr_en, rd_en, addr_err;
  logic [7:0] tdr_q, tdr_d;
  logic [7:0] tcr_q, tcr_d;
  logic [7:0] tier_q, tier_d;
  logic       load_q, load_d;
  logic       clr_ovf_q, clr_ovf_d;
  logic       clr_udf_q, clr_udf_d;
  logic       irq_q, irq_d;
  logic [7:0] tsr_view;

  timer_apb_if u_apb_if (
    .clk      (clk),
    .rst      (rst),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pready   (pready),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr_err (addr_err)
  );

  always_comb begin
    tdr_d     = tdr_q;
    tcr_d     = tcr_q;
    tier_d    = tier_q;
    load_d    = 1'b0;
    clr_ovf_d = 1'b0;
    clr_udf_d = 1'b0;
    if (wr_en) begin
      case (paddr)
        ADDR_TDR: tdr_d = pwdata;
        ADDR_TCR: begin
          tcr_d  = pwdata & TCR_STORE_MASK;
          load_d = pwdata[TCR_LOAD];
        end
        ADDR_TSR: begin
          clr_ovf_d = pwdata[TSR_OVF];
          clr_udf_d = pwdata[TSR_UDF];
        end
        ADDR_TIER: tier_d = pwdata & TIER_STORE_MASK;
        default: ;
      endcase
    end
  end

  // Flags belong to the counter; irq only sees them through the enables.
  always_comb begin
    irq_d = (overflow && tier_q[TIER_OVF_IE]) || (underflow && tier_q[TIER_UDF_IE]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdr_q     <= TDR_RST;
      tcr_q     <= TCR_RST;
      tier_q    <= TIER_RST;
      load_q    <= 1'b0;
      clr_ovf_q <= 1'b0;
      clr_udf_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      tdr_q     <= tdr_d;
      tcr_q     <= tcr_d;
      tier_q    <= tier_d;
      load_q    <= load_d;
      clr_ovf_q <= clr_ovf_d;
      clr_udf_q <= clr_udf_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    tsr_view          = 8'h00;
    tsr_view[TSR_OVF] = overflow;
    tsr_view[TSR_UDF] = underflow;
  end

  always_comb begin
    prdata = 8'h00;
    if (rd_en) begin
      case (paddr)
        ADDR_TDR:  prdata = tdr_q;
        ADDR_TCR:  prdata = tcr_q;
        ADDR_TSR:  prdata = tsr_view;
        ADDR_TIER: prdata = tier_q;
        default:   prdata = 8'h00;
      endcase
    end
  end

  assign pslverr       = addr_err;
  assign start_counter = tdr_q;
  assign up_down       = tcr_q[TCR_UP_DOWN];
  assign enable        = tcr_q[TCR_ENABLE];
  assign cks           = tcr_q[TCR_CKS_LSB +: 2];
  assign load          = load_q;
  assign clr_overflow  = clr_ovf_q;
  assign clr_underflow = clr_udf_q;
  assign irq           = irq_q;

endmodule
